// File: rtl/gshare_pkg.sv
// Shared types and saturating-counter helpers for the gshare predictor.
package gshare_pkg;

   typedef enum logic {INIT, RUN} state_t;

   // Counters are handled in a 4-bit container (widest legal counter) and narrowed by the caller.
   function automatic logic [3:0] ctr_mask(input int bits);
      return 4'((1 << bits) - 1);
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] ctr, input int bits);
      logic [3:0] top;
      top = ctr_mask(bits);
      return (ctr >= top) ? top : ctr + 4'd1;
   endfunction

   function automatic logic [3:0] sat_dec(input logic [3:0] ctr, input int bits);
      return (ctr == 4'd0) ? 4'd0 : ((ctr - 4'd1) & ctr_mask(bits));
   endfunction

   function automatic logic [3:0] weak_nt(input int bits);
      return 4'((1 << (bits - 1)) - 1);
   endfunction

endpackage

// File: rtl/gshare_ghr.sv
// Global history register: speculative shift-in, with restore taking priority.
module gshare_ghr #(
   parameter int HIST_BITS = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 shift_en,
   input  logic                 shift_bit,
   input  logic                 restore_en,
   input  logic [HIST_BITS-1:0] restore_val,
   output logic [HIST_BITS-1:0] ghr
);

   // Shift-then-OR keeps HIST_BITS = 1 legal (the old bit simply falls off).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr <= '0;
      end else if (restore_en) begin
         ghr <= restore_val;
      end else if (shift_en) begin
         ghr <= (ghr << 1) | HIST_BITS'(shift_bit);
      end
   end

endmodule

// File: rtl/gshare_predictor_param.sv
// Parametrised gshare direction predictor: zero-latency lookup, decoupled counter update,
// speculative history with mispredict restore, and a post-reset table initialisation sweep.
module gshare_predictor_param
   import gshare_pkg::*;
#(
   parameter int INDEX_BITS = 10,
   parameter int HIST_BITS  = 10,
   parameter int CTR_BITS   = 2,
   parameter int ADDR_BITS  = 32,
   parameter int PC_LSB     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ready,
   input  logic                  pred_valid,
   input  logic [ADDR_BITS-1:0]  pred_pc,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_index,
   output logic [HIST_BITS-1:0]  pred_hist,
   input  logic                  upd_valid,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic [HIST_BITS-1:0]  upd_hist,
   input  logic                  upd_taken,
   input  logic                  upd_mispredict
);

   localparam int DEPTH = 1 << INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] LAST_ENTRY = INDEX_BITS'(DEPTH - 1);
   localparam logic [CTR_BITS-1:0]   WEAK_NT    = CTR_BITS'(weak_nt(CTR_BITS));

   state_t                state;
   logic [INDEX_BITS-1:0] sweep_ptr;
   logic [HIST_BITS-1:0]  ghr;
   logic [HIST_BITS-1:0]  restore_val;
   logic [CTR_BITS-1:0]   ctr_mem [DEPTH];
   logic [CTR_BITS-1:0]   upd_ctr;
   logic [CTR_BITS-1:0]   upd_next;
   logic                  unused_pc;

   // Only the index window of the PC matters; the rest is deliberately ignored.
   assign unused_pc = ^pred_pc;

   assign pred_index = pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
   assign pred_hist  = ghr;
   assign pred_taken = ready & ctr_mem[pred_index][CTR_BITS-1];

   assign upd_ctr  = ctr_mem[upd_index];
   assign upd_next = upd_taken ? CTR_BITS'(sat_inc(4'(upd_ctr), CTR_BITS))
                               : CTR_BITS'(sat_dec(4'(upd_ctr), CTR_BITS));

   assign restore_val = (upd_hist << 1) | HIST_BITS'(upd_taken);

   gshare_ghr #(
      .HIST_BITS (HIST_BITS)
   ) u_ghr (
      .clk         (clk),
      .reset       (reset),
      .shift_en    (pred_valid & ready),
      .shift_bit   (pred_taken),
      .restore_en  (upd_valid & upd_mispredict & ready),
      .restore_val (restore_val),
      .ghr         (ghr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= INIT;
         sweep_ptr <= '0;
         ready     <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               sweep_ptr <= sweep_ptr + INDEX_BITS'(1);
               if (sweep_ptr == LAST_ENTRY) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            default: begin
               state <= RUN;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // Table has no reset; the sweep owns the write port until every entry is defined.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         ctr_mem[sweep_ptr] <= WEAK_NT;
      end else if (upd_valid) begin
         ctr_mem[upd_index] <= upd_next;
      end
   end

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Scoreboard bench for gshare_predictor_param: directed vectors, monitor-side comparison.
module tb_gshare_predictor_param;

   localparam int IB = 10;
   localparam int HB = 10;
   localparam int AB = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ready;
   logic          pred_valid = 1'b0;
   logic [AB-1:0] pred_pc = '0;
   logic          pred_taken;
   logic [IB-1:0] pred_index;
   logic [HB-1:0] pred_hist;
   logic          upd_valid = 1'b0;
   logic [IB-1:0] upd_index = '0;
   logic [HB-1:0] upd_hist = '0;
   logic          upd_taken = 1'b0;
   logic          upd_mispredict = 1'b0;

   always #5 clk = ~clk;

   gshare_predictor_param #(
      .INDEX_BITS (IB),
      .HIST_BITS  (HB),
      .CTR_BITS   (2),
      .ADDR_BITS  (AB),
      .PC_LSB     (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ready          (ready),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_taken     (pred_taken),
      .pred_index     (pred_index),
      .pred_hist      (pred_hist),
      .upd_valid      (upd_valid),
      .upd_index      (upd_index),
      .upd_hist       (upd_hist),
      .upd_taken      (upd_taken),
      .upd_mispredict (upd_mispredict)
   );

   typedef struct {
      logic          taken;
      logic [HB-1:0] hist;
      logic [IB-1:0] idx;
   } pexp_t;

   pexp_t         pq[$];
   int            rq[$];
   int            checks = 0;
   int            errors = 0;
   logic [HB-1:0] ghr_m = '0;
   bit            done = 1'b0;
   bit            fin_checked = 1'b0;
   int            init_cnt = 0;
   bit            ready_seen = 1'b0;

   // Monitor: all comparisons happen here, against expectations queued by the stimulus.
   always @(negedge clk) begin
      pexp_t e;
      int    exp_cnt;
      if (!reset) begin
         init_cnt   = 0;
         ready_seen = 1'b0;
      end else if (!ready) begin
         init_cnt++;
         checks++;
         if (pred_taken !== 1'b0 || pred_hist !== '0) begin
            errors++;
            $display("FAIL init_outputs: pred_taken=%b pred_hist=%h, required 0 / 000", pred_taken, pred_hist);
         end
      end else if (!ready_seen) begin
         ready_seen = 1'b1;
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL ready_rise: unexpected rise after %0d cycles", init_cnt);
         end else begin
            exp_cnt = rq.pop_front();
            if (init_cnt != exp_cnt) begin
               errors++;
               $display("FAIL ready_latency: ready low for %0d cycles, required %0d", init_cnt, exp_cnt);
            end
         end
      end

      if (reset && ready && pred_valid) begin
         checks++;
         if (pq.size() == 0) begin
            errors++;
            $display("FAIL pred_unexpected: lookup at index %h with no expectation", pred_index);
         end else begin
            e = pq.pop_front();
            if (pred_taken !== e.taken) begin
               errors++;
               $display("FAIL pred_taken idx=%h: got %b, required %b", e.idx, pred_taken, e.taken);
            end
            checks++;
            if (pred_hist !== e.hist) begin
               errors++;
               $display("FAIL pred_hist idx=%h: got %h, required %h", e.idx, pred_hist, e.hist);
            end
            checks++;
            if (pred_index !== e.idx) begin
               errors++;
               $display("FAIL pred_index: got %h, required %h", pred_index, e.idx);
            end
         end
      end

      if (done && !fin_checked) begin
         fin_checked = 1'b1;
         checks++;
         if (pq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d lookups and %0d ready events never observed, required 0/0", pq.size(), rq.size());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit dp, input int pidx, input bit ptk,
                      input bit du, input int uidx, input bit utk, input bit umis,
                      input logic [HB-1:0] uh);
      pexp_t e;
      pred_valid = dp;
      upd_valid  = du;
      if (dp) begin
         pred_pc = AB'(IB'(pidx) ^ IB'(ghr_m)) << 2;
         e.taken = ptk;
         e.hist  = ghr_m;
         e.idx   = IB'(pidx);
         pq.push_back(e);
      end
      upd_index      = IB'(uidx);
      upd_taken      = utk;
      upd_mispredict = umis;
      upd_hist       = uh;
      step();
      if (du && umis)  ghr_m = HB'({uh, utk});
      else if (dp)     ghr_m = HB'({ghr_m, ptk});
      pred_valid     = 1'b0;
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic pred(input int idx, input bit tk);
      cyc(1'b1, idx, tk, 1'b0, 0, 1'b0, 1'b0, '0);
   endtask

   task automatic upd(input int idx, input bit tk);
      cyc(1'b0, 0, 1'b0, 1'b1, idx, tk, 1'b0, '0);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 2000; i++) begin
         if (ready) return;
         step();
      end
      $display("FAIL ready_timeout: ready never rose within 2000 cycles");
      $fatal(1, "ready timeout");
   endtask

   initial begin
      // Power-up sweep
      repeat (3) step();
      rq.push_back(1024);
      reset = 1'b1;
      wait_ready();
      step();

      // Fresh table predicts weakly not-taken everywhere
      pred(0, 1'b0);
      pred(10'h3FF, 1'b0);
      pred(10'h100, 1'b0);

      // Train index 5 to strongly taken
      upd(5, 1'b1);
      upd(5, 1'b1);
      pred(5, 1'b1);

      // Saturation at both ends of index 5
      upd(5, 1'b1);
      upd(5, 1'b1);
      upd(5, 1'b1);
      pred(5, 1'b1);
      upd(5, 1'b0);
      pred(5, 1'b1);
      upd(5, 1'b0);
      pred(5, 1'b0);
      upd(5, 1'b0);
      pred(5, 1'b0);
      upd(5, 1'b0);
      pred(5, 1'b0);
      upd(5, 1'b1);
      pred(5, 1'b0);
      upd(5, 1'b1);
      pred(5, 1'b1);

      // Speculative shift, then restore overriding a same-cycle lookup
      upd(7, 1'b1);
      upd(7, 1'b1);
      pred(7, 1'b1);
      pred(30, 1'b0);
      cyc(1'b1, 40, 1'b0, 1'b1, 20, 1'b1, 1'b1, 10'h2AA);
      pred(41, 1'b0);
      pred(20, 1'b1);

      // Same-cycle predict/update of index 9: no bypass
      cyc(1'b1, 9, 1'b0, 1'b1, 9, 1'b1, 1'b0, '0);
      pred(9, 1'b1);

      // Reset from RUN, then abort the sweep at cycle 500 and restart it
      reset = 1'b0;
      ghr_m = '0;
      step();
      reset = 1'b1;
      pred_valid = 1'b1;
      pred_pc    = 32'h0000_0014;
      upd_valid  = 1'b1;
      upd_index  = 10'd5;
      upd_taken  = 1'b1;
      repeat (500) step();
      pred_valid = 1'b0;
      upd_valid  = 1'b0;
      reset = 1'b0;
      repeat (3) step();
      rq.push_back(1024);
      reset = 1'b1;
      wait_ready();
      step();
      pred(5, 1'b0);
      pred(9, 1'b0);

      done = 1'b1;
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
